alu_bist: RTL and testbench

- Synthesizable built-in self-test engine that drives the 4-bit ALU operand/opcode interface and checks its result and flag outputs.
- Sweeps every combination of opcode, carry-in, A and B (8 x 2 x 16 x 16 = 4096 vectors).
- Compares each response against an internal golden model and reports the error count, the first failing vector and a pass/fail verdict.
- Sits beside the ALU at the ALU boundary so the datapath can be self-tested in silicon or on FPGA.

---
 rtl/alu_bist_pkg.sv | 29 ++
 rtl/alu_ref.sv | 52 +++++
 rtl/alu_bist.sv | 120 ++++++++++++
 tb/tb_alu_bist.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_bist_pkg.sv
// Shared ALU definitions for the BIST engine and its golden model: width,
// opcode encoding, FSM states and the arithmetic/logic classification rule.
package alu_bist_pkg;

    localparam int ALU_W = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_INC  = 3'b001,
        OP_NEGA = 3'b010,
        OP_NEGB = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_NOTA = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } bist_state_e;

    // Carry and sign only carry meaning for the adder half of the opcode map.
    function automatic logic is_arith(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/alu_ref.sv
// Combinational golden ALU: expected result and flags for one vector, plus
// the mask saying whether carry/sign are meaningful for this opcode.
module alu_ref
    import alu_bist_pkg::*;
#(
    parameter int W = ALU_W
) (
    input  logic [2:0]   op,
    input  logic         cin,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] r,
    output logic         z,
    output logic         c,
    output logic         s,
    output logic         cmp_sc
);

    logic [W:0] sum;
    logic [W:0] ax;
    logic [W:0] bx;
    logic [W:0] cx;
    logic [W:0] one;

    assign ax  = {1'b0, a};
    assign bx  = {1'b0, b};
    assign cx  = {{W{1'b0}}, cin};
    assign one = (W+1)'(1);

    // One extra bit of headroom so the carry-out falls out of the add.
    always_comb begin
        sum = '0;
        case (alu_op_e'(op))
            OP_ADD:  sum = ax + bx + cx;
            OP_INC:  sum = ax + one + cx;
            OP_NEGA: sum = {1'b0, ~a} + one + cx;
            OP_NEGB: sum = {1'b0, ~b} + one + cx;
            OP_AND:  sum = {1'b0, a & b};
            OP_OR:   sum = {1'b0, a | b};
            OP_XOR:  sum = {1'b0, a ^ b};
            OP_NOTA: sum = {1'b0, ~a};
            default: sum = '0;
        endcase
    end

    assign r      = sum[W-1:0];
    assign c      = sum[W];
    assign z      = (sum[W-1:0] == '0);
    assign s      = sum[W-1];
    assign cmp_sc = is_arith(op);

endmodule

// File: rtl/alu_bist.sv
// Built-in self-test engine: sweeps every {op,cin,A,B} vector into the ALU,
// checks the response against alu_ref and reports count, first failure, verdict.
module alu_bist
    import alu_bist_pkg::*;
#(
    parameter int W      = ALU_W,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             start,
    output logic [2:0]       alu_op,
    output logic [W-1:0]     alu_a,
    output logic [W-1:0]     alu_b,
    output logic             alu_cin,
    input  logic [W-1:0]     alu_r,
    input  logic             alu_z,
    input  logic             alu_c,
    input  logic             alu_s,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [2*W+4:0]   err_count,
    output logic             first_err_vld,
    output logic [2*W+3:0]   first_err_vec
);

    localparam int IW = 2*W + 4;
    localparam int EW = 2*W + 5;
    localparam int CW = $clog2(SETTLE + 1);

    bist_state_e   state;
    bist_state_e   state_nxt;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic          sample;
    logic          last;
    logic          launch;
    logic          mism;

    logic [W-1:0]  ref_r;
    logic          ref_z;
    logic          ref_c;
    logic          ref_s;
    logic          ref_cmp;

    // The index register is the drive bus: B innermost, op outermost.
    assign {alu_op, alu_cin, alu_a, alu_b} = idx;

    assign sample = (state == S_RUN) && (cnt == CW'(SETTLE));
    assign last   = sample && (idx == '1);
    assign launch = (state != S_RUN) && start;
    assign busy   = (state == S_RUN);
    assign done   = (state == S_DONE);

    alu_ref #(.W(W)) u_ref (
        .op     (alu_op),
        .cin    (alu_cin),
        .a      (alu_a),
        .b      (alu_b),
        .r      (ref_r),
        .z      (ref_z),
        .c      (ref_c),
        .s      (ref_s),
        .cmp_sc (ref_cmp)
    );

    assign mism = (alu_r != ref_r) || (alu_z != ref_z) ||
                  (ref_cmp && ((alu_c != ref_c) || (alu_s != ref_s)));

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_RUN;
            S_RUN:   if (last)  state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_RUN : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            idx           <= '0;
            cnt           <= '0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
            pass          <= 1'b0;
        end else if (launch) begin
            idx           <= '0;
            cnt           <= '0;
            err_count     <= '0;
            first_err_vld <= 1'b0;
            first_err_vec <= '0;
            pass          <= 1'b0;
        end else if (state == S_RUN) begin
            if (sample) begin
                cnt <= '0;
                idx <= idx + IW'(1);
                if (mism) begin
                    err_count <= err_count + EW'(1);
                    if (!first_err_vld) begin
                        first_err_vec <= idx;
                        first_err_vld <= 1'b1;
                    end
                end
                // Verdict must include the last vector's own compare.
                if (last) pass <= (err_count == '0) && !mism;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: a behavioural ALU with selectable faults, and a
// whole-sweep reference that predicts error count and first failing vector.
module tb_alu_bist;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  alu_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_cin;
    logic [3:0]  alu_r;
    logic        alu_z;
    logic        alu_c;
    logic        alu_s;
    logic        busy;
    logic        done;
    logic        pass;
    logic [12:0] err_count;
    logic        first_err_vld;
    logic [11:0] first_err_vec;
    logic [6:0]  rsp;

    // fault modes: 0 none, 1 R=0 on AND, 2 c inverted on logic ops,
    // 3 carry stuck-at-0 on ADD, 4 R bit flip on one random {op,cin,A} slice
    int fault_mode = 0;
    int f_op = 0, f_cin = 0, f_a = 0, f_bit = 0;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_bist #(.W(4), .SETTLE(1)) dut (
        .clk           (clk),
        .nreset        (nreset),
        .start         (start),
        .alu_op        (alu_op),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_cin       (alu_cin),
        .alu_r         (alu_r),
        .alu_z         (alu_z),
        .alu_c         (alu_c),
        .alu_s         (alu_s),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_vld (first_err_vld),
        .first_err_vec (first_err_vec)
    );

    // {R[3:0], z, c, s} from plain integer arithmetic
    function automatic logic [6:0] golden(int op, int cin, int a, int b);
        int t;
        int r;
        case (op)
            0: t = a + b + cin;
            1: t = a + 1 + cin;
            2: t = (15 - a) + 1 + cin;
            3: t = (15 - b) + 1 + cin;
            4: t = a & b;
            5: t = a | b;
            6: t = a ^ b;
            default: t = 15 - a;
        endcase
        r = t % 16;
        return {4'(r), r == 0, t > 15, r > 7};
    endfunction

    function automatic logic [6:0] alu_model(int op, int cin, int a, int b,
                                             int mode, int fo, int fc, int fa, int fb);
        logic [6:0] g;
        logic [3:0] r;
        logic       z, c, s;
        g = golden(op, cin, a, b);
        {r, z, c, s} = g;
        case (mode)
            1: if (op == 4) begin r = 4'd0; z = 1'b1; s = 1'b0; end
            2: if (op >= 4) c = ~c;
            3: if (op == 0) c = 1'b0;
            4: if (op == fo && cin == fc && a == fa) begin
                   r = r ^ (4'd1 << fb);
                   z = (r == 4'd0);
                   s = r[3];
               end
            default: ;
        endcase
        return {r, z, c, s};
    endfunction

    assign rsp = alu_model(int'(alu_op), int'(alu_cin), int'(alu_a), int'(alu_b),
                           fault_mode, f_op, f_cin, f_a, f_bit);
    assign {alu_r, alu_z, alu_c, alu_s} = rsp;

    // Predict the outcome of a whole sweep under the current fault mode.
    task automatic ref_sweep(output int cnt, output logic [11:0] first, output logic vld);
        int op, cin, a, b;
        logic [6:0] g, f;
        logic miss;
        cnt = 0; first = '0; vld = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            op = i / 512; cin = (i / 256) % 2; a = (i / 16) % 16; b = i % 16;
            g = golden(op, cin, a, b);
            f = alu_model(op, cin, a, b, fault_mode, f_op, f_cin, f_a, f_bit);
            miss = (g[6:2] != f[6:2]) || (op < 4 && g[1:0] != f[1:0]);
            if (miss) begin
                if (!vld) first = 12'(i);
                vld = 1'b1;
                cnt++;
            end
        end
    endtask

    // Launch one sweep and follow it to the done pulse (bounded).
    task automatic run_sweep(input bit hold, output int busy_cyc, output int drive_bad,
                             output bit timeout);
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        busy_cyc = 0; drive_bad = 0; timeout = 1'b1;
        for (int k = 0; k < 20000; k++) begin
            if (done) begin timeout = 1'b0; break; end
            if (busy) begin
                if ({alu_op, alu_cin, alu_a, alu_b} !== 12'(busy_cyc / 2)) drive_bad++;
                busy_cyc++;
            end
            @(negedge clk);
        end
        n_vec++;
        if (timeout) begin
            n_err++;
            $display("FAIL sweep_timeout: no done pulse within 20000 cycles");
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        #1;
        n_vec++;
        if ({alu_op, alu_a, alu_b, alu_cin} !== 12'd0) begin
            n_err++; $display("FAIL reset_drive: got %h want 0", {alu_op, alu_a, alu_b, alu_cin});
        end
        n_vec++;
        if ({busy, done, pass, err_count, first_err_vld, first_err_vec} !== 29'd0) begin
            n_err++;
            $display("FAIL reset_status: busy=%b done=%b pass=%b err=%0d fv=%b fe=%h want all 0",
                     busy, done, pass, err_count, first_err_vld, first_err_vec);
        end
        @(negedge clk) nreset = 1'b1;
        @(negedge clk);
    endtask

    // Shared post-sweep checks are written out in each test on purpose.
    task automatic test_clean();
        int bc, db, ec; logic [11:0] ef; logic ev; bit to;
        fault_mode = 0;
        ref_sweep(ec, ef, ev);
        run_sweep(1'b0, bc, db, to);
        n_vec++; if (bc !== 8192) begin n_err++; $display("FAIL clean_busy_len: got %0d want 8192", bc); end
        n_vec++; if (db !== 0) begin n_err++; $display("FAIL clean_drive_order: %0d bad cycles want 0", db); end
        n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL clean_pass: got %b want 1", pass); end
        n_vec++; if (err_count !== 13'(ec)) begin n_err++; $display("FAIL clean_err: got %0d want %0d", err_count, ec); end
        n_vec++; if (first_err_vld !== ev) begin n_err++; $display("FAIL clean_fvld: got %b want %b", first_err_vld, ev); end
        @(negedge clk);
        n_vec++; if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++; $display("FAIL clean_done_pulse: done=%b busy=%b want 0 0", done, busy);
        end
        n_vec++; if (pass !== 1'b1) begin n_err++; $display("FAIL clean_pass_hold: got %b want 1", pass); end
    endtask

    task automatic test_and_zero();
        int bc, db, ec; logic [11:0] ef; logic ev; bit to;
        fault_mode = 1;
        ref_sweep(ec, ef, ev);
        run_sweep(1'b0, bc, db, to);
        n_vec++; if (err_count !== 13'd350 || ec != 350) begin
            n_err++; $display("FAIL and_zero_err: got %0d model %0d want 350", err_count, ec);
        end
        n_vec++; if (first_err_vec !== 12'b100_0_0001_0001 || ef !== first_err_vec) begin
            n_err++; $display("FAIL and_zero_first: got %b want 100000010001", first_err_vec);
        end
        n_vec++; if (pass !== 1'b0 || first_err_vld !== 1'b1) begin
            n_err++; $display("FAIL and_zero_verdict: pass=%b fvld=%b want 0 1", pass, first_err_vld);
        end
    endtask

    task automatic test_logic_c_inv();
        int bc, db, ec; logic [11:0] ef; logic ev; bit to;
        fault_mode = 2;
        ref_sweep(ec, ef, ev);
        run_sweep(1'b0, bc, db, to);
        n_vec++; if (err_count !== 13'(ec) || pass !== 1'b1 || first_err_vld !== 1'b0) begin
            n_err++; $display("FAIL c_masked: err=%0d pass=%b fvld=%b want %0d 1 0", err_count, pass, first_err_vld, ec);
        end
    endtask

    task automatic test_carry_stuck();
        int bc, db, ec; logic [11:0] ef; logic ev; bit to;
        fault_mode = 3;
        ref_sweep(ec, ef, ev);
        run_sweep(1'b0, bc, db, to);
        n_vec++; if (err_count !== 13'd256 || ec != 256) begin
            n_err++; $display("FAIL carry_err: got %0d model %0d want 256", err_count, ec);
        end
        n_vec++; if (first_err_vec !== 12'b000_0_0001_1111 || pass !== 1'b0) begin
            n_err++; $display("FAIL carry_first: got %b pass=%b want 000000011111 0", first_err_vec, pass);
        end
    endtask

    task automatic test_random_fault();
        int bc, db, ec; logic [11:0] ef; logic ev; bit to;
        for (int it = 0; it < 2; it++) begin
            fault_mode = 4;
            f_op = int'($urandom_range(0, 7)); f_cin = int'($urandom_range(0, 1));
            f_a = int'($urandom_range(0, 15)); f_bit = int'($urandom_range(0, 3));
            ref_sweep(ec, ef, ev);
            run_sweep(1'b0, bc, db, to);
            n_vec++; if (err_count !== 13'(ec) || first_err_vec !== ef || first_err_vld !== ev) begin
                n_err++;
                $display("FAIL rand_fault op=%0d cin=%0d a=%0d bit=%0d: err=%0d fe=%h fv=%b want %0d %h %b",
                         f_op, f_cin, f_a, f_bit, err_count, first_err_vec, first_err_vld, ec, ef, ev);
            end
            n_vec++; if (pass !== (ec == 0)) begin
                n_err++; $display("FAIL rand_pass: got %b want %b", pass, ec == 0);
            end
        end
    endtask

    task automatic test_reset_mid();
        int bc, db, ec; logic [11:0] ef; logic ev; bit to; bit hit;
        fault_mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            if ({alu_op, alu_cin, alu_a, alu_b} == 12'd1000) begin hit = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++; if (!hit) begin n_err++; $display("FAIL mid_reach: index 1000 not reached"); end
        nreset = 1'b0;
        #1;
        n_vec++;
        if ({alu_op, alu_a, alu_b, alu_cin, busy, done, pass, err_count, first_err_vld, first_err_vec} !== 41'd0) begin
            n_err++; $display("FAIL mid_reset_zero: busy=%b err=%0d drive=%h want all 0",
                              busy, err_count, {alu_op, alu_cin, alu_a, alu_b});
        end
        @(negedge clk) nreset = 1'b1;
        fault_mode = 0;
        ref_sweep(ec, ef, ev);
        run_sweep(1'b0, bc, db, to);
        n_vec++; if (bc !== 8192 || err_count !== 13'(ec) || pass !== 1'b1) begin
            n_err++; $display("FAIL mid_resweep: busy=%0d err=%0d pass=%b want 8192 %0d 1", bc, err_count, pass, ec);
        end
    endtask

    task automatic test_start_held();
        int bc, db; bit to;
        fault_mode = 0;
        run_sweep(1'b1, bc, db, to);
        n_vec++; if (bc !== 8192 || pass !== 1'b1) begin
            n_err++; $display("FAIL held_sweep: busy=%0d pass=%b want 8192 1", bc, pass);
        end
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 || err_count !== 13'd0 || first_err_vld !== 1'b0) begin
            n_err++; $display("FAIL held_restart: busy=%b done=%b pass=%b err=%0d want 1 0 0 0",
                              busy, done, pass, err_count);
        end
        start = 1'b0;
        nreset = 1'b0;
        @(negedge clk) nreset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_and_zero();
        test_logic_c_inv();
        test_carry_stuck();
        test_random_fault();
        test_reset_mid();
        test_start_held();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
